// File: rtl/sd_step_pkg.sv
// sd_step_pkg: shared state encoding for the single-step controller
package sd_step_pkg;
    localparam int ST_W = 3;
    typedef enum logic [ST_W-1:0] {ST_IDLE, ST_ARM, ST_PULSE, ST_LOW, ST_WAIT} step_state_t;
endpackage

// File: rtl/sd_step_cap_fifo.sv
// sd_step_cap_fifo: capture buffer; a push on full without a same-cycle pop is dropped and flagged
module sd_step_cap_fifo #(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic             drop,
    output logic [width-1:0] rd_data
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL = (AW+1)'(depth);
    logic [width-1:0] mem_q [depth];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic full, do_push, do_pop;
    // pointer and occupancy update; a pop frees the slot a same-cycle push needs
    always_comb begin
        full = cnt_q == FULL;
        do_pop = pop && cnt_q != '0;
        do_push = push && (!full || do_pop);
        drop = push && !do_push;
        wr_d = wr_q + AW'(do_push);
        rd_d = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    // pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    // storage; contents are irrelevant while empty so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end
    assign empty = cnt_q == '0;
    assign rd_data = mem_q[rd_q];
endmodule

// File: rtl/sd_step_ctrl.sv
// sd_step_ctrl: runs N single-steps of the shim, retrying pulses until each step yields one transfer
module sd_step_ctrl
    import sd_step_pkg::*;
#(
    parameter int width = 32,
    parameter int cntw = 8,
    parameter int depth = 4,
    parameter int retry_gap = 16,
    parameter int max_tries = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_srdy,
    output logic             cmd_drdy,
    input  logic [cntw-1:0]  cmd_count,
    output logic             step_en,
    output logic             step,
    input  logic             mon_srdy,
    input  logic             mon_drdy,
    input  logic [width-1:0] mon_data,
    output logic             cap_srdy,
    input  logic             cap_drdy,
    output logic [width-1:0] cap_data,
    output logic             busy,
    output logic [cntw-1:0]  done_cnt,
    output logic             timeout,
    output logic             overflow
);
    localparam int GW = $clog2(retry_gap + 1);
    localparam int TW = $clog2(max_tries + 1);
    step_state_t state_q, state_d;
    logic [cntw-1:0] n_q, n_d, done_q, done_d;
    logic [TW-1:0] tries_q, tries_d;
    logic [GW-1:0] gap_q, gap_d;
    logic got_q, got_d, step_en_q, step_en_d, timeout_q, timeout_d, overflow_q, overflow_d;
    logic counted, cap_empty, cap_drop;
    // got_q blocks a second transfer being credited to the pulse that already produced one
    assign counted = state_q != ST_IDLE && mon_srdy && mon_drdy && !got_q;
    sd_step_cap_fifo #(.width(width), .depth(depth)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(counted),
        .push_data(mon_data),
        .pop(cap_drdy),
        .empty(cap_empty),
        .drop(cap_drop),
        .rd_data(cap_data)
    );
    // next-state: command accept, pulse sequencing, retry/timeout, transfer accounting
    always_comb begin
        state_d = state_q;
        n_d = n_q;
        done_d = done_q;
        tries_d = tries_q;
        gap_d = gap_q;
        got_d = got_q;
        step_en_d = step_en_q;
        timeout_d = timeout_q;
        overflow_d = overflow_q | cap_drop;
        if (counted) begin
            done_d = done_q + cntw'(1);
            tries_d = '0;
            got_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (cmd_srdy) begin
                    done_d = '0;
                    step_en_d = cmd_count != '0;
                    if (cmd_count != '0) begin
                        n_d = cmd_count;
                        tries_d = '0;
                        got_d = 1'b0;
                        timeout_d = 1'b0;
                        overflow_d = 1'b0;
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: state_d = ST_PULSE;
            ST_PULSE: state_d = ST_LOW;
            ST_LOW: begin
                gap_d = '0;
                state_d = (got_q || counted) ? ST_PULSE : ST_WAIT;
            end
            ST_WAIT: begin
                if (counted) begin
                    state_d = ST_PULSE;
                end else if (gap_q == GW'(retry_gap - 1)) begin
                    gap_d = '0;
                    tries_d = tries_q + TW'(1);
                    timeout_d = tries_d == TW'(max_tries);
                    state_d = timeout_d ? ST_IDLE : ST_PULSE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (counted && done_d == n_q) state_d = ST_IDLE;
        if (state_d == ST_PULSE && state_q != ST_PULSE) got_d = 1'b0;
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q <= '0;
            done_q <= '0;
            tries_q <= '0;
            gap_q <= '0;
            got_q <= 1'b0;
            step_en_q <= 1'b0;
            timeout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q <= n_d;
            done_q <= done_d;
            tries_q <= tries_d;
            gap_q <= gap_d;
            got_q <= got_d;
            step_en_q <= step_en_d;
            timeout_q <= timeout_d;
            overflow_q <= overflow_d;
        end
    end
    assign cmd_drdy = state_q == ST_IDLE;
    assign busy = !cmd_drdy;
    assign step = state_q == ST_PULSE;
    assign step_en = step_en_q;
    assign cap_srdy = !cap_empty;
    assign done_cnt = done_q;
    assign timeout = timeout_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_sd_step_ctrl.sv
// tb_sd_step_ctrl: shim/sink model driving the controller, capture scoreboard checked by a separate monitor
module tb_sd_step_ctrl;
    localparam int W = 32, CW = 8, D = 4, GAP = 16, TRIES = 4;
    logic clk = 0, rst = 1, cmd_srdy = 0, mon_srdy = 0, mon_drdy = 0, cap_drdy = 0;
    logic [CW-1:0] cmd_count = '0;
    logic [W-1:0] mon_data = '0;
    logic cmd_drdy, step_en, step, cap_srdy, busy, timeout, overflow;
    logic [W-1:0] cap_data;
    logic [CW-1:0] done_cnt;
    int total = 0, bad = 0;
    logic [W-1:0] exp_q[$];
    bit exp_ovf = 0, prev_step = 0, cap_rand = 0, full_b, popping;
    int n_xfer = 0, pulses = 0, sink_mode = 1, low_until = 0, cyc = 0;

    sd_step_ctrl #(.width(W), .cntw(CW), .depth(D), .retry_gap(GAP), .max_tries(TRIES)) dut (
        .clk(clk), .rst(rst), .cmd_srdy(cmd_srdy), .cmd_drdy(cmd_drdy), .cmd_count(cmd_count),
        .step_en(step_en), .step(step), .mon_srdy(mon_srdy), .mon_drdy(mon_drdy), .mon_data(mon_data),
        .cap_srdy(cap_srdy), .cap_drdy(cap_drdy), .cap_data(cap_data), .busy(busy),
        .done_cnt(done_cnt), .timeout(timeout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: the reference capture buffer is a plain queue of depth D
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            full_b = exp_q.size() == D;
            chk("cap_srdy", cap_srdy, exp_q.size() != 0);
            popping = cap_drdy && exp_q.size() != 0;
            if (popping) chk("cap_data", cap_data, exp_q.pop_front());
            if (mon_srdy && mon_drdy) begin
                if (full_b && !popping) exp_ovf = 1;
                else exp_q.push_back(mon_data);
            end
        end
    end

    // one clock: retire a completed transfer, offer new data on each step rise, drive the sink
    task automatic tick();
        bit x;
        x = mon_srdy & mon_drdy;
        @(posedge clk);
        #1;
        cyc++;
        if (x) begin
            mon_srdy = 0;
            n_xfer++;
        end
        if (step) chk("step_low_gap", prev_step, 0);
        if (step && !prev_step) begin
            pulses++;
            if (!mon_srdy) begin
                mon_srdy = 1;
                mon_data = $urandom;
            end
        end
        prev_step = step;
        case (sink_mode)
            0: mon_drdy = 0;
            1: mon_drdy = 1;
            2: mon_drdy = $urandom_range(0, 3) != 0;
            default: mon_drdy = cyc >= low_until;
        endcase
        if (cap_rand) cap_drdy = $urandom_range(0, 1);
    endtask

    task automatic issue(input int n);
        cmd_count = CW'(n);
        cmd_srdy = 1;
        n_xfer = 0;
        pulses = 0;
        if (n != 0) exp_ovf = 0;
        tick();
        cmd_srdy = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!cmd_drdy && k < 1000) begin
            tick();
            k++;
        end
        chk("idle_reached", cmd_drdy, 1);
        chk("busy_low", busy, 0);
    endtask

    task automatic drain();
        int k = 0;
        cap_rand = 0;
        cap_drdy = 1;
        while (exp_q.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        tick();
        chk("drain_empty", cap_srdy, 0);
        cap_drdy = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_drdy", cmd_drdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_step_en", step_en, 0);
        chk("rst_step", step, 0);
        chk("rst_cap_srdy", cap_srdy, 0);
        chk("rst_done", done_cnt, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_overflow", overflow, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk_reset_vals();
        rst = 0;
        tick();

        // three steps against an always-ready sink, captures held then popped in order
        sink_mode = 1;
        issue(3);
        chk("step_en_on", step_en, 1);
        wait_idle();
        chk("t1_pulses", pulses, 3);
        chk("t1_xfers", n_xfer, 3);
        chk("t1_done", done_cnt, 3);
        chk("t1_timeout", timeout, 0);
        drain();

        // sink stalled 40 cycles: two retries, success on the third pulse
        sink_mode = 3;
        low_until = cyc + 40;
        mon_drdy = 0;
        issue(1);
        wait_idle();
        chk("t2_pulses", pulses, 3);
        chk("t2_done", done_cnt, 1);
        chk("t2_timeout", timeout, 0);
        drain();

        // sink never ready: max_tries pulses, then abort
        sink_mode = 0;
        mon_drdy = 0;
        issue(2);
        wait_idle();
        chk("t3_pulses", pulses, TRIES);
        chk("t3_done", done_cnt, 0);
        chk("t3_timeout", timeout, 1);
        mon_srdy = 0;

        // count 0 releases stepping and leaves the stickies alone
        issue(0);
        chk("t4_step_en", step_en, 0);
        chk("t4_cmd_drdy", cmd_drdy, 1);
        chk("t4_done", done_cnt, 0);
        chk("t4_timeout", timeout, 1);
        repeat (5) tick();
        chk("t4_pulses", pulses, 0);

        // six captures into a four-entry buffer with no host pops
        sink_mode = 1;
        issue(6);
        wait_idle();
        chk("t5_done", done_cnt, 6);
        chk("t5_timeout", timeout, 0);
        chk("t5_overflow", overflow, exp_ovf);
        chk("t5_ovf_set", overflow, 1);
        drain();

        // randomized sink and host pops
        sink_mode = 2;
        cap_rand = 1;
        for (int i = 0; i < 20; i++) begin
            int n;
            n = $urandom_range(1, 5);
            issue(n);
            wait_idle();
            chk("rnd_done", done_cnt, n);
            chk("rnd_xfers", n_xfer, n);
            chk("rnd_timeout", timeout, 0);
            chk("rnd_overflow", overflow, exp_ovf);
        end
        drain();

        // reset while waiting on a stalled step with captures pending
        sink_mode = 1;
        issue(2);
        wait_idle();
        sink_mode = 0;
        mon_drdy = 0;
        issue(3);
        repeat (8) tick();
        chk("t7_busy", busy, 1);
        rst = 1;
        mon_srdy = 0;
        tick();
        chk_reset_vals();
        rst = 0;
        tick();
        chk("t7_cap_after", cap_srdy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
